// File: rtl/dm_port_arbiter_pkg.sv
// Purpose: shared types and constants for the DataMemory port arbiter.
//   - dm_state_e : arbiter FSM encoding (ST_PIPE / ST_RESP, 1 bit)
//   - DM_ADDR_W  : default DataMemory word-address width
//   - DM_DATA_W  : default data width
//   - starve_w() : width of a saturating counter that reaches a given max
package dm_port_arbiter_pkg;

  typedef enum logic {
    ST_PIPE = 1'b0,  // pipeline owns the port, external may be granted
    ST_RESP = 1'b1   // one-cycle slot after an external grant, pipeline only
  } dm_state_e;

  localparam int DM_ADDR_W = 9;
  localparam int DM_DATA_W = 32;

  function automatic int starve_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dm_starve_ctr.sv
// Purpose: saturating up-counter with clear, used to track how long a
//   requester has been denied access to a shared port.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset (count -> 0)
//   inc_i  : increment by one, saturating at MAX
//   clr_i  : clear to zero (wins over inc_i)
//   cnt_o  : current count
//   sat_o  : count has reached MAX
module dm_starve_ctr #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == MAX_V);

endmodule

// File: rtl/dm_port_arbiter.sv
// Purpose: shares the single-port DataMemory between the pipeline MEM
//   stage and an external port (loader/debug/DMA). The pipeline has
//   priority; after STARVE_MAX consecutive denied external cycles the
//   external side is forced in and StallMem freezes the pipeline for that
//   one cycle. Every external grant is followed by one guaranteed
//   pipeline cycle (ST_RESP), in which read data is presented.
// Ports:
//   Clk, Reset                         : clock, synchronous active-high reset
//   MemWriteM/MemToRegM/ALUOutM/WriteDataM : pipeline store/load request
//   ReadDataM                          : load data back to pipeline
//   StallMem                           : freeze pipeline (forced ext grant)
//   ExtReq/ExtWe/ExtAddr/ExtWData      : external request, held until ExtAck
//   ExtAck                             : access performed this cycle
//   ExtRValid/ExtRData                 : read data, cycle after ExtAck
//   DMA/DMWD/DMWE/DMRD                 : DataMemory port
//   AddrErr                            : sticky pipeline out-of-range flag
//   dbg_state_o/dbg_starve_o           : FSM state and starvation count
//
// External handshake: ExtReq is the valid; ExtAck is the ready. A transfer
// happens in exactly the cycle where both are high. The requester must keep
// ExtWe/ExtAddr/ExtWData stable while ExtReq is high and ExtAck is low;
// dropping ExtReq before ExtAck cancels the request with no access.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DM_ADDR_W,
  parameter int DATA_W     = DM_DATA_W,
  parameter int STARVE_MAX = 4,
  localparam int SW        = starve_w(STARVE_MAX)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MemWriteM,
  input  logic              MemToRegM,
  input  logic [31:0]       ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              StallMem,
  input  logic              ExtReq,
  input  logic              ExtWe,
  input  logic [ADDR_W-1:0] ExtAddr,
  input  logic [DATA_W-1:0] ExtWData,
  output logic              ExtAck,
  output logic              ExtRValid,
  output logic [DATA_W-1:0] ExtRData,
  output logic [ADDR_W-1:0] DMA,
  output logic [DATA_W-1:0] DMWD,
  output logic              DMWE,
  input  logic [DATA_W-1:0] DMRD,
  output logic              AddrErr,
  output logic              dbg_state_o,
  output logic [SW-1:0]     dbg_starve_o
);

  dm_state_e         state_q, state_d;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              addr_err_q;

  logic              pipe_act;
  logic              addr_oor;
  logic              ext_gnt;
  logic              starve_inc;
  logic              starve_clr;
  logic              starve_sat;
  logic [SW-1:0]     starve_cnt;

  assign pipe_act = MemWriteM | MemToRegM;
  assign addr_oor = pipe_act & (|ALUOutM[31:ADDR_W]);

  // No grant while Reset is held, so nothing external commits during reset.
  assign ext_gnt = !Reset && (state_q == ST_PIPE) && ExtReq &&
                   (!pipe_act || starve_sat);

  // Starvation only advances in ST_PIPE; ST_RESP holds the count.
  assign starve_clr = (state_q == ST_PIPE) && (ext_gnt || !ExtReq);
  assign starve_inc = (state_q == ST_PIPE) && !ext_gnt && ExtReq;

  dm_starve_ctr #(
    .MAX (STARVE_MAX),
    .W   (SW)
  ) u_starve (
    .clk_i (Clk),
    .rst_i (Reset),
    .inc_i (starve_inc),
    .clr_i (starve_clr),
    .cnt_o (starve_cnt),
    .sat_o (starve_sat)
  );

  // Port mux: pipeline by default, external only in a grant cycle.
  always_comb begin
    DMA     = ALUOutM[ADDR_W-1:0];
    DMWD    = WriteDataM;
    DMWE    = MemWriteM & ~addr_oor;
    state_d = ST_PIPE;
    if (ext_gnt) begin
      DMA     = ExtAddr;
      DMWD    = ExtWData;
      DMWE    = ExtWe;
      state_d = ST_RESP;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_PIPE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= ext_gnt & ~ExtWe;
      if (ext_gnt && !ExtWe) begin
        rdata_q <= DMRD;
      end
      // Only a pipeline access that actually owns the port flags an error.
      if (addr_oor && !ext_gnt) begin
        addr_err_q <= 1'b1;
      end
    end
  end

  assign ReadDataM    = addr_oor ? '0 : DMRD;
  assign StallMem     = ext_gnt & pipe_act;
  assign ExtAck       = ext_gnt;
  // A reset landing in ST_RESP abandons the read: hide the pending pulse.
  assign ExtRValid    = rvalid_q & ~Reset;
  assign ExtRData     = rdata_q;
  assign AddrErr      = addr_err_q;
  assign dbg_state_o  = state_q;
  assign dbg_starve_o = starve_cnt;

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

  localparam int AW   = 9;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int SW   = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          Reset;
  logic          MemWriteM, MemToRegM;
  logic [31:0]   ALUOutM;
  logic [DW-1:0] WriteDataM, ReadDataM;
  logic          StallMem;
  logic          ExtReq, ExtWe;
  logic [AW-1:0] ExtAddr;
  logic [DW-1:0] ExtWData;
  logic          ExtAck, ExtRValid;
  logic [DW-1:0] ExtRData;
  logic [AW-1:0] DMA;
  logic [DW-1:0] DMWD, DMRD;
  logic          DMWE;
  logic          AddrErr;
  logic          dbg_state;
  logic [SW-1:0] dbg_starve;

  dm_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SMAX)
  ) dut (
    .Clk          (clk),
    .Reset        (Reset),
    .MemWriteM    (MemWriteM),
    .MemToRegM    (MemToRegM),
    .ALUOutM      (ALUOutM),
    .WriteDataM   (WriteDataM),
    .ReadDataM    (ReadDataM),
    .StallMem     (StallMem),
    .ExtReq       (ExtReq),
    .ExtWe        (ExtWe),
    .ExtAddr      (ExtAddr),
    .ExtWData     (ExtWData),
    .ExtAck       (ExtAck),
    .ExtRValid    (ExtRValid),
    .ExtRData     (ExtRData),
    .DMA          (DMA),
    .DMWD         (DMWD),
    .DMWE         (DMWE),
    .DMRD         (DMRD),
    .AddrErr      (AddrErr),
    .dbg_state_o  (dbg_state),
    .dbg_starve_o (dbg_starve)
  );

  // DataMemory: synchronous write, combinational read.
  logic          mem_init;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    end else if (DMWE) begin
      mem[DMA] <= DMWD;
    end
  end
  assign DMRD = mem[DMA];

  // ---------------- scoreboard ----------------
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic pipe(input logic we, input logic rd, input logic [31:0] a, input logic [31:0] d);
    MemWriteM  = we;
    MemToRegM  = rd;
    ALUOutM    = a;
    WriteDataM = d;
  endtask

  task automatic ext(input logic req, input logic we, input logic [AW-1:0] a, input logic [31:0] d);
    ExtReq   = req;
    ExtWe    = we;
    ExtAddr  = a;
    ExtWData = d;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ---------------- directed vectors ----------------
  logic [11:0] ack_mask;
  int          stalls;

  initial begin
    Reset    = 1'b1;
    mem_init = 1'b1;
    pipe(0, 0, 0, 0);
    ext(0, 0, 0, 0);
    step();
    mem_init = 1'b0;

    // T1: reset with ExtReq held
    ext(1, 1, 9'd5, 32'h55);
    pipe(1, 0, 32'd3, 32'h33);
    #1;
    check_eq("t1_ack_rst", ExtAck, 1'b0);
    check_eq("t1_stall_rst", StallMem, 1'b0);
    check_eq("t1_dmwe_pipe", DMWE, 1'b1);
    check_eq("t1_dma_pipe", DMA, 9'd3);
    step();
    pipe(0, 0, 32'd3, 32'h0);
    #1;
    check_eq("t1_dmwe_off", DMWE, 1'b0);
    check_eq("t1_ack_rst2", ExtAck, 1'b0);
    step();
    Reset = 1'b0;
    ext(0, 0, 0, 0);
    #1;
    check_eq("t1_addrerr", AddrErr, 1'b0);
    check_eq("t1_rvalid", ExtRValid, 1'b0);
    check_eq("t1_rdata", ExtRData, 32'h0);
    check_eq("t1_state", dbg_state, 1'b0);
    check_eq("t1_starve", dbg_starve, 3'd0);
    check_eq("t1_mem5", mem[5], 32'h0);
    check_eq("t1_mem3", mem[3], 32'h33);
    step();

    // T2: idle pipe, external write granted same cycle
    ext(1, 1, 9'h1F0, 32'hDEADBEEF);
    #1;
    check_eq("t2_ack", ExtAck, 1'b1);
    check_eq("t2_stall", StallMem, 1'b0);
    check_eq("t2_dmwe", DMWE, 1'b1);
    check_eq("t2_dma", DMA, 9'h1F0);
    step();
    ext(0, 0, 0, 0);
    pipe(0, 1, 32'h1F0, 0);
    #1;
    check_eq("t2_state_resp", dbg_state, 1'b1);
    check_eq("t2_ack_resp", ExtAck, 1'b0);
    check_eq("t2_rvalid_wr", ExtRValid, 1'b0);
    check_eq("t2_mem", mem[9'h1F0], 32'hDEADBEEF);
    check_eq("t2_lw", ReadDataM, 32'hDEADBEEF);
    step();

    // T3: busy pipe starves an external read; forced grant on cycle 5
    ext(1, 0, 9'h1F0, 0);
    for (int i = 1; i <= 4; i++) begin
      if (i % 2 == 1) pipe(1, 0, 32'h10 + i, 32'h1000 + i);
      else            pipe(0, 1, 32'h1F0, 0);
      #1;
      check_eq($sformatf("t3_ack_c%0d", i), ExtAck, 1'b0);
      check_eq($sformatf("t3_stall_c%0d", i), StallMem, 1'b0);
      check_eq($sformatf("t3_starve_c%0d", i), dbg_starve, i - 1);
      if (i % 2 == 0) check_eq($sformatf("t3_lw_c%0d", i), ReadDataM, 32'hDEADBEEF);
      step();
    end
    pipe(1, 0, 32'h20, 32'hCAFE0005);
    #1;
    check_eq("t3_ack_c5", ExtAck, 1'b1);
    check_eq("t3_stall_c5", StallMem, 1'b1);
    check_eq("t3_dma_c5", DMA, 9'h1F0);
    check_eq("t3_dmwe_c5", DMWE, 1'b0);
    exp_q.push_back(32'hDEADBEEF);
    step();
    ext(0, 0, 0, 0);
    #1;
    check_eq("t3_rvalid_c6", ExtRValid, 1'b1);
    check_eq("t3_state_c6", dbg_state, 1'b1);
    check_eq("t3_dmwe_c6", DMWE, 1'b1);
    check_eq("t3_dma_c6", DMA, 9'h20);
    if (exp_q.size() > 0) check_eq("t3_rdata", ExtRData, exp_q.pop_front());
    else check_eq("t3_sb_nonempty", 32'(exp_q.size()), 32'd1);
    step();
    pipe(0, 0, 0, 0);
    #1;
    check_eq("t3_mem20", mem[9'h20], 32'hCAFE0005);
    check_eq("t3_mem11", mem[9'h11], 32'h1001);
    check_eq("t3_mem13", mem[9'h13], 32'h1003);
    check_eq("t3_rvalid_c7", ExtRValid, 1'b0);
    check_eq("t3_rdata_hold", ExtRData, 32'hDEADBEEF);
    step();

    // T4: held ExtReq -> ST_RESP gap gives the pipeline a slot
    ext(1, 1, 9'h40, 32'h40404040);
    pipe(0, 0, 0, 0);
    #1;
    check_eq("t4_ack_a", ExtAck, 1'b1);
    step();
    pipe(1, 0, 32'h41, 32'h41);
    #1;
    check_eq("t4_ack_b", ExtAck, 1'b0);
    check_eq("t4_dmwe_b", DMWE, 1'b1);
    check_eq("t4_dma_b", DMA, 9'h41);
    step();
    pipe(0, 0, 0, 0);
    #1;
    check_eq("t4_ack_c", ExtAck, 1'b1);
    check_eq("t4_dma_c", DMA, 9'h40);
    step();
    pipe(1, 0, 32'h43, 32'h43);
    #1;
    check_eq("t4_ack_d", ExtAck, 1'b0);
    check_eq("t4_dma_d", DMA, 9'h43);
    step();
    ack_mask = '0;
    stalls   = 0;
    for (int i = 0; i < 12; i++) begin
      pipe(0, 1, 32'h1F0, 0);
      #1;
      ack_mask[i] = ExtAck;
      stalls += int'(StallMem);
      step();
    end
    check_eq("t4_ack_mask", ack_mask, 12'h410);
    check_eq("t4_stalls", stalls, 2);

    // ExtReq withdrawn before grant: no access, starve cleared
    ext(1, 1, 9'h50, 32'h5050);
    #1;
    check_eq("t4_mem40", mem[9'h40], 32'h40404040);
    check_eq("t4_mem41", mem[9'h41], 32'h41);
    check_eq("t4_mem43", mem[9'h43], 32'h43);
    check_eq("t4_starve_e1", dbg_starve, 3'd0);
    step();
    #1;
    check_eq("t4_starve_e2", dbg_starve, 3'd1);
    step();
    ext(0, 1, 9'h50, 32'h5050);
    #1;
    check_eq("t4_starve_e3", dbg_starve, 3'd2);
    check_eq("t4_ack_e3", ExtAck, 1'b0);
    step();
    pipe(0, 0, 0, 0);
    #1;
    check_eq("t4_starve_clr", dbg_starve, 3'd0);
    check_eq("t4_mem50", mem[9'h50], 32'h0);
    step();

    // T5: out-of-range pipeline access
    pipe(1, 0, 32'h0, 32'hA5A5A5A5);
    #1;
    step();
    pipe(1, 0, 32'h200, 32'h12345678);
    #1;
    check_eq("t5_dmwe_oor", DMWE, 1'b0);
    check_eq("t5_addrerr_pre", AddrErr, 1'b0);
    step();
    pipe(0, 1, 32'h200, 0);
    #1;
    check_eq("t5_lw_oor", ReadDataM, 32'h0);
    check_eq("t5_addrerr", AddrErr, 1'b1);
    check_eq("t5_mem0", mem[0], 32'hA5A5A5A5);
    step();
    pipe(0, 1, 32'h0, 0);
    #1;
    check_eq("t5_lw_inrange", ReadDataM, 32'hA5A5A5A5);
    step();
    pipe(0, 0, 0, 0);
    step();
    step();
    #1;
    check_eq("t5_addrerr_sticky", AddrErr, 1'b1);

    // T6: reset lands in ST_RESP of an external read
    ext(1, 0, 9'h40, 0);
    #1;
    check_eq("t6_ack", ExtAck, 1'b1);
    step();
    Reset = 1'b1;
    ext(0, 0, 0, 0);
    #1;
    check_eq("t6_state_resp", dbg_state, 1'b1);
    check_eq("t6_rvalid_rst", ExtRValid, 1'b0);
    step();
    Reset = 1'b0;
    #1;
    check_eq("t6_rvalid_after", ExtRValid, 1'b0);
    check_eq("t6_state", dbg_state, 1'b0);
    check_eq("t6_starve", dbg_starve, 3'd0);
    check_eq("t6_addrerr_clr", AddrErr, 1'b0);
    step();

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
